fpga_serial_lut_alu: RTL and testbench
======================================

# fpga_serial_lut_alu

Parametrised successor to the fixed 8-bit bitfile-configured adder tile. Operands of WIDTH bits are processed LSB-first, one bit per clock, through two 3-input LUTs: a sum LUT and a carry LUT. The LUTs, together with the carry-in, come from a configuration word shifted in serially. One configured tile therefore performs add, subtract, or a bitwise function, with a start/busy/done handshake for use inside the larger fabric.

## Interface
- WIDTH, 8, operand/result width in bits (>= 2)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state including configuration
- cfg_en  in  1  shift enable for configuration bitstream
- cfg_bit  in  1  serial configuration data
- start  in  1  request an operation; sampled on the rising edge
- operand_a  in  WIDTH  first operand, latched on accepted start
- operand_b  in  WIDTH  second operand, latched on accepted start
- result  out  WIDTH  result of last completed operation
- c_out  out  1  final carry-LUT output of last completed operation
- zero  out  1  high when result == 0, updated with result
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when result/c_out/zero update
- configured  out  1  at least 17 config bits shifted in since reset

## Operation
- Config register is 17 bits: {cin, carry_lut[7:0], sum_lut[7:0]}.
- Each cycle with cfg_en=1 and busy=0, the register shifts left and takes cfg_bit into bit 0. Transmit order: cin, carry_lut[7]…[0], sum_lut[7]…[0].
- A 5-bit saturating counter counts shifts. configured=1 once the count reaches 17, and stays 1 until reset. Further shifts keep overwriting the register.
- cfg_en while busy=1 is ignored.
- LUT index per bit i is {a_i, b_i, c}, i.e. idx = 4·a_i + 2·b_i + c.
  - s_i = sum_lut[idx]
  - c_next = carry_lut[idx]
  - c starts as cin.
- FSM states:
  - IDLE → RUN: on start=1 with configured=1. Latch operands, load c=cin, clear bit counter, internal result shift register cleared.
  - RUN: each edge processes bit k (k = 0..WIDTH-1), shifts s_k into the internal register, and updates c.
  - RUN → IDLE: after bit WIDTH-1. Copy the internal register to result, set c_out to the final c and zero to (result==0), and pulse done.
- start with configured=0, or while busy=1, is ignored (no queueing).
- result, c_out and zero hold their values through later runs until the next completion; no intermediate values are visible.
- Width rule: result is exactly WIDTH bits. Overflow is reported only via c_out.

## Timing
- Reset values: result=0, c_out=0, zero=0, busy=0, done=0, configured=0, config register=0, FSM=IDLE.
- Reset is asynchronous and takes effect immediately.
- Let edge E0 sample an accepted start:
  - busy=1 from after E0.
  - Edges E1..E_WIDTH process bits 0..WIDTH-1.
  - After E_WIDTH: busy=0, done=1 for exactly one cycle, outputs updated.
  - Latency: WIDTH+1 edges from start to done.
- Back-to-back: start=1 in the cycle done=1 is accepted at the next edge, giving throughput of one operation per WIDTH+1 cycles.
- Reset mid-run aborts immediately:
  - All outputs go to 0, including configured.
  - The tile must be reconfigured before the next start.
- cfg_en and start asserted together in IDLE: both take effect. The operation uses the pre-shift configuration, and the shift also completes.

## Test plan
- **Reset and unconfigured start:** hold reset 2 cycles, release, pulse start with configured=0 → all outputs stay 0, busy never asserts.
- **Add:** shift cin=0, carry_lut=0xE8, sum_lut=0x96 (configured rises after 17th bit).
  - 64+64 → result=128, c_out=0, done exactly 9 edges after start.
  - 100+100 → result=200, c_out=0.
  - 64+128 → result=192, c_out=0.
- **Add boundary cases:**
  - 255+1 → result=0, c_out=1, zero=1.
  - 127+1 → result=128, c_out=0.
  - Issue the second start in the done cycle → accepted; second done 9 edges later.
- **Subtract:** cin=1, carry_lut=0xB2, sum_lut=0x69.
  - 5−3 → result=2, c_out=1.
  - 3−5 → result=254, c_out=0.
  - 7−7 → result=0, zero=1, c_out=1.
- **Bitwise XOR:** cin=0, carry_lut=0x00, sum_lut=0x3C.
  - 0xAA,0x55 → result=0xFF, c_out=0.
  - start and cfg_en pulsed during busy → ignored; result unchanged until done.
- **Reset mid-run:** assert reset at bit 3 of an add → all outputs 0 immediately; a subsequent start before reconfiguration is ignored. Repeat the whole plan with WIDTH=16: 0xFFFF+1 → result=0, c_out=1, latency 17 edges.

Source files
------------

// File: rtl/fpga_serial_lut_alu.sv
// Bit-serial LUT ALU tile: two 3-input LUTs (sum, carry) plus carry-in loaded from a
// serial configuration stream; operands are processed LSB-first, one bit per clock.
module fpga_serial_lut_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             cfg_en_i,
    input  logic             cfg_bit_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             c_out_o,
    output logic             zero_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             configured_o
);
    localparam int unsigned CFG_W = 17;
    localparam int unsigned LUT_W = 16;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned BIT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CFG_FULL = CNT_W'(CFG_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CFG_W-1:0] cfg_q, cfg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             configured_q, configured_d;
    logic [LUT_W-1:0] lut_q, lut_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sr_q, sr_d;
    logic             c_q, c_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             c_out_q, c_out_d, zero_q, zero_d, done_q, done_d;
    logic [2:0]       lut_idx;
    logic             sum_bit, carry_bit;

    // lut_q = {carry_lut, sum_lut}; index {a_i, b_i, c}
    assign lut_idx   = {a_q[0], b_q[0], c_q};
    assign sum_bit   = lut_q[{1'b0, lut_idx}];
    assign carry_bit = lut_q[{1'b1, lut_idx}];

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i && configured_q) state_d = S_RUN;
            S_RUN:   if (bit_q == LAST_BIT)       state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_d        = cfg_q;
        cnt_d        = cnt_q;
        configured_d = configured_q;
        lut_d        = lut_q;
        a_d          = a_q;
        b_d          = b_q;
        sr_d         = sr_q;
        c_d          = c_q;
        bit_d        = bit_q;
        result_d     = result_q;
        c_out_d      = c_out_q;
        zero_d       = zero_q;
        done_d       = 1'b0;

        if (cfg_en_i && (state_q == S_IDLE)) begin
            cfg_d = {cfg_q[CFG_W-2:0], cfg_bit_i};
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d >= CFG_FULL) configured_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                // LUTs are snapshotted so a concurrent config shift cannot disturb the run
                if (start_i && configured_q) begin
                    a_d   = operand_a_i;
                    b_d   = operand_b_i;
                    c_d   = cfg_q[CFG_W-1];
                    lut_d = cfg_q[LUT_W-1:0];
                    bit_d = '0;
                    sr_d  = '0;
                end
            end
            S_RUN: begin
                sr_d  = {sum_bit, sr_q[WIDTH-1:1]};
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                c_d   = carry_bit;
                bit_d = bit_q + BIT_W'(1);
                if (bit_q == LAST_BIT) begin
                    result_d = sr_d;
                    c_out_d  = carry_bit;
                    zero_d   = (sr_d == '0);
                    done_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cfg_q        <= '0;
            cnt_q        <= '0;
            configured_q <= 1'b0;
            lut_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            sr_q         <= '0;
            c_q          <= 1'b0;
            bit_q        <= '0;
            result_q     <= '0;
            c_out_q      <= 1'b0;
            zero_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            cfg_q        <= cfg_d;
            cnt_q        <= cnt_d;
            configured_q <= configured_d;
            lut_q        <= lut_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sr_q         <= sr_d;
            c_q          <= c_d;
            bit_q        <= bit_d;
            result_q     <= result_d;
            c_out_q      <= c_out_d;
            zero_q       <= zero_d;
            done_q       <= done_d;
        end
    end

    assign result_o     = result_q;
    assign c_out_o      = c_out_q;
    assign zero_o       = zero_q;
    assign busy_o       = (state_q == S_RUN);
    assign done_o       = done_q;
    assign configured_o = configured_q;

endmodule

// File: tb/tb_fpga_serial_lut_alu.sv
// Directed bench for fpga_serial_lut_alu: an 8-bit and a 16-bit tile share control inputs.
module tb_fpga_serial_lut_alu;
    logic        clk = 1'b0, rst = 1'b1, cfg_en = 1'b0, cfg_bit = 1'b0, start = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, r8;
    logic [15:0] a16 = '0, b16 = '0, r16;
    logic        c8, z8, busy8, done8, cf8, c16, z16, busy16, done16, cf16;
    int          checks = 0, errors = 0;

    localparam logic [16:0] CFG_ADD = {1'b0, 8'hE8, 8'h96};
    localparam logic [16:0] CFG_SUB = {1'b1, 8'hB2, 8'h69};
    localparam logic [16:0] CFG_XOR = {1'b0, 8'h00, 8'h3C};

    typedef struct {
        logic [16:0] cfg;
        logic        w16;
        logic [15:0] a, b, r;
        logic        c, z;
    } vec_t;

    fpga_serial_lut_alu #(.WIDTH(8)) dut8 (
        .clock_i(clk), .reset_i(rst), .cfg_en_i(cfg_en), .cfg_bit_i(cfg_bit), .start_i(start),
        .operand_a_i(a8), .operand_b_i(b8), .result_o(r8), .c_out_o(c8), .zero_o(z8),
        .busy_o(busy8), .done_o(done8), .configured_o(cf8));

    fpga_serial_lut_alu #(.WIDTH(16)) dut16 (
        .clock_i(clk), .reset_i(rst), .cfg_en_i(cfg_en), .cfg_bit_i(cfg_bit), .start_i(start),
        .operand_a_i(a16), .operand_b_i(b16), .result_o(r16), .c_out_o(c16), .zero_o(z16),
        .busy_o(busy16), .done_o(done16), .configured_o(cf16));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic shift_cfg(input logic [16:0] w, input bit chk_cfg);
        for (int i = 16; i >= 0; i--) begin
            @(negedge clk);
            if (chk_cfg && i == 0) chk("configured_after_16", 32'(cf8), 32'd0);
            cfg_en  = 1'b1;
            cfg_bit = w[i];
        end
        @(negedge clk);
        cfg_en = 1'b0;
        if (chk_cfg) chk("configured_after_17", 32'({cf16, cf8}), 32'd3);
    endtask

    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        a8 = a[7:0]; b8 = b[7:0]; a16 = a; b16 = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // n counts active edges since the start-sampling edge (E0 gives n=1)
    task automatic wait_done(input bit w16, inout int n);
        while (!(w16 ? done16 : done8) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy8 || busy16) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL idle_timeout busy8=%0d busy16=%0d", busy8, busy16);
        end
    endtask

    task automatic run_op(input string name, input bit w16, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] er, input logic ec, input logic ez);
        int n = 1;
        @(negedge clk);
        launch(a, b);
        chk({name, "_busy"}, 32'(w16 ? busy16 : busy8), 32'd1);
        wait_done(w16, n);
        chk({name, "_latency"}, 32'(n), w16 ? 32'd17 : 32'd9);
        chk({name, "_result"}, w16 ? 32'(r16) : 32'(r8), 32'(er));
        chk({name, "_cout"}, 32'(w16 ? c16 : c8), 32'(ec));
        chk({name, "_zero"}, 32'(w16 ? z16 : z8), 32'(ez));
        @(posedge clk); #1;
        chk({name, "_done_pulse"}, 32'(w16 ? done16 : done8), 32'd0);
        wait_idle();
    endtask

    task automatic expect_ignored(input string name);
        bit seen = 1'b0;
        @(negedge clk);
        launch(16'd1, 16'd1);
        for (int i = 0; i < 12; i++) begin
            if (busy8 || busy16 || done8 || done16) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk({name, "_never_busy"}, 32'(seen), 32'd0);
        chk({name, "_result"}, 32'({r16, r8}), 32'd0);
    endtask

    initial begin
        vec_t vecs[11];
        logic [16:0] cur;
        int n;

        vecs[0]  = '{CFG_ADD, 1'b0, 16'd64,    16'd64,    16'd128,   1'b0, 1'b0};
        vecs[1]  = '{CFG_ADD, 1'b0, 16'd100,   16'd100,   16'd200,   1'b0, 1'b0};
        vecs[2]  = '{CFG_ADD, 1'b0, 16'd64,    16'd128,   16'd192,   1'b0, 1'b0};
        vecs[3]  = '{CFG_ADD, 1'b0, 16'd255,   16'd1,     16'd0,     1'b1, 1'b1};
        vecs[4]  = '{CFG_ADD, 1'b0, 16'd127,   16'd1,     16'd128,   1'b0, 1'b0};
        vecs[5]  = '{CFG_ADD, 1'b1, 16'hFFFF,  16'h0001,  16'h0000,  1'b1, 1'b1};
        vecs[6]  = '{CFG_ADD, 1'b1, 16'h1234,  16'h4321,  16'h5555,  1'b0, 1'b0};
        vecs[7]  = '{CFG_SUB, 1'b0, 16'd5,     16'd3,     16'd2,     1'b1, 1'b0};
        vecs[8]  = '{CFG_SUB, 1'b0, 16'd3,     16'd5,     16'd254,   1'b0, 1'b0};
        vecs[9]  = '{CFG_SUB, 1'b0, 16'd7,     16'd7,     16'd0,     1'b1, 1'b1};
        vecs[10] = '{CFG_XOR, 1'b0, 16'h00AA,  16'h0055,  16'h00FF,  1'b0, 1'b0};

        // reset held two cycles, then start without configuration
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({r8, c8, z8, busy8, done8, cf8}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        expect_ignored("unconfigured_start");

        shift_cfg(CFG_ADD, 1'b1);
        cur = CFG_ADD;

        foreach (vecs[i]) begin
            if (vecs[i].cfg != cur) begin
                shift_cfg(vecs[i].cfg, 1'b0);
                cur = vecs[i].cfg;
            end
            run_op($sformatf("vec%0d", i), vecs[i].w16, vecs[i].a, vecs[i].b,
                   vecs[i].r, vecs[i].c, vecs[i].z);
        end

        // back-to-back: second start issued in the done cycle
        shift_cfg(CFG_ADD, 1'b0);
        @(negedge clk);
        launch(16'd10, 16'd20);
        n = 1;
        wait_done(1'b0, n);
        chk("b2b_first_result", 32'(r8), 32'd30);
        launch(16'd1, 16'd2);
        n = 1;
        chk("b2b_second_busy", 32'(busy8), 32'd1);
        wait_done(1'b0, n);
        chk("b2b_second_latency", 32'(n), 32'd9);
        chk("b2b_second_result", 32'(r8), 32'd3);
        wait_idle();

        // start and cfg_en while busy are ignored; result holds until done
        shift_cfg(CFG_XOR, 1'b0);
        @(negedge clk);
        launch(16'h00AA, 16'h0055);
        n = 1;
        repeat (3) begin
            start = 1'b1; cfg_en = 1'b1; cfg_bit = 1'b1; a8 = 8'h00; b8 = 8'h00;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0; cfg_en = 1'b0;
        chk("busy_ignore_hold", 32'({done8, r8}), 32'd3);
        wait_done(1'b0, n);
        chk("busy_ignore_latency", 32'(n), 32'd9);
        chk("busy_ignore_result", 32'(r8), 32'hFF);
        wait_idle();
        run_op("xor_cfg_intact", 1'b0, 16'h000F, 16'h0000, 16'h000F, 1'b0, 1'b0);

        // start and cfg shift in the same idle cycle: run uses old cfg, shift lands
        @(negedge clk);
        cfg_en = 1'b1; cfg_bit = 1'b1;
        launch(16'd3, 16'd5);
        cfg_en = 1'b0;
        n = 1;
        wait_done(1'b0, n);
        chk("simul_result", 32'(r8), 32'd6);
        wait_idle();
        run_op("simul_shifted", 1'b0, 16'd0, 16'd0, 16'h00FF, 1'b0, 1'b0);

        // reset mid-run clears everything without a clock edge
        shift_cfg(CFG_ADD, 1'b0);
        @(negedge clk);
        launch(16'd100, 16'd27);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("midrun_reset_result", 32'({r16, r8}), 32'd0);
        chk("midrun_reset_flags", 32'({c8, z8, busy8, done8, cf8, c16, busy16, cf16}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        expect_ignored("post_reset_start");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
